// File: rtl/motor_pkg.sv
// motor_pkg: shared state type, period constants and the duty slew helper
// used by the motor PWM driver (motor_pwm_driver and pwm_deadtime).
package motor_pkg;

  localparam int PWM_PERIOD_BITS = 8;
  localparam logic [PWM_PERIOD_BITS-1:0] DUTY_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    HIGH_ON,
    LOW_ON,
    FAULT
  } pwm_state_t;

  // Move cur toward tgt by at most step, landing exactly on tgt when it is within reach.
  // The difference is taken as a 9-bit signed value so nothing wraps at 0 or 255.
  function automatic logic [7:0] slewToward(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [7:0] step);
    logic signed [8:0] diff;
    logic signed [8:0] stepS;
    diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    stepS = $signed({1'b0, step});
    if (diff > stepS) begin
      slewToward = cur + step;
    end else if (diff < -stepS) begin
      slewToward = cur - step;
    end else begin
      slewToward = tgt;
    end
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: half-bridge gate sequencer. Turns the raw PWM level into
// complementary gate drive with a dead window between every change of side,
// and holds both gates off while disabled or faulted.
module pwm_deadtime
  import motor_pkg::*;
#(
  parameter int DEAD_TIME = 4
) (
  input  logic c20k,
  input  logic reset,
  input  logic raw,
  input  logic enable,
  input  logic kill,
  input  logic clear,
  output logic highSide,
  output logic lowSide,
  output logic faulted
);

  localparam logic [3:0] DeadLoad = 4'(DEAD_TIME);

  pwm_state_t stateReg, stateNext;
  logic [3:0] deadCntReg, deadCntNext;
  logic       targetReg, targetNext;
  logic       highSideReg, lowSideReg, faultedReg;

  // State and counter registers; gate flops are loaded from the next state so both
  // sides always come from one state value and can never be high together.
  always_ff @(posedge c20k) begin
    if (reset) begin
      stateReg    <= IDLE;
      deadCntReg  <= 4'd0;
      targetReg   <= 1'b0;
      highSideReg <= 1'b0;
      lowSideReg  <= 1'b0;
      faultedReg  <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      deadCntReg  <= deadCntNext;
      targetReg   <= targetNext;
      highSideReg <= (stateNext == HIGH_ON);
      lowSideReg  <= (stateNext == LOW_ON);
      faultedReg  <= (stateNext == FAULT);
    end
  end

  // Next-state logic: normal sequencing first, then disable, then fault overrides on top.
  always_comb begin
    stateNext   = stateReg;
    deadCntNext = deadCntReg;
    targetNext  = targetReg;
    case (stateReg)
      IDLE: begin
        if (enable) begin
          stateNext   = DEAD;
          targetNext  = raw;
          deadCntNext = DeadLoad;
        end
      end
      DEAD: begin
        if (raw != targetReg) begin
          // Raw moved again inside the window: restart toward the new side.
          targetNext  = raw;
          deadCntNext = DeadLoad;
        end else if (deadCntReg <= 4'd1) begin
          stateNext   = targetReg ? HIGH_ON : LOW_ON;
          deadCntNext = 4'd0;
        end else begin
          deadCntNext = deadCntReg - 4'd1;
        end
      end
      HIGH_ON: begin
        if (!raw) begin
          stateNext   = DEAD;
          targetNext  = 1'b0;
          deadCntNext = DeadLoad;
        end
      end
      LOW_ON: begin
        if (raw) begin
          stateNext   = DEAD;
          targetNext  = 1'b1;
          deadCntNext = DeadLoad;
        end
      end
      FAULT: begin
        if (clear && !kill) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    if (!enable && (stateReg != FAULT)) begin
      stateNext   = IDLE;
      deadCntNext = 4'd0;
    end
    if (kill) begin
      stateNext   = FAULT;
      deadCntNext = 4'd0;
    end
  end

  assign highSide = highSideReg;
  assign lowSide  = lowSideReg;
  assign faulted  = faultedReg;

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: 8-bit period PWM for one half-bridge with period-synchronous
// duty shadowing, dead time, enable gating and latched fault shutdown.
// Optional: define MOTOR_PWM_SLEW_LIMIT_EN to limit the duty change per period to SLEW_STEP.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int DEAD_TIME = 4,
  parameter int SLEW_STEP = 4
) (
  input  logic       c20k,
  input  logic       reset,
  input  logic       Enable,
  input  logic [7:0] MotorSignal,
  input  logic       Fault,
  input  logic       FaultClear,
  output logic       HighSide,
  output logic       LowSide,
  output logic       PeriodStart,
  output logic [7:0] AppliedDuty,
  output logic       Faulted
);

`ifdef MOTOR_PWM_SLEW_LIMIT_EN
  localparam logic [7:0] StepLimit = 8'(SLEW_STEP);
`else
  // Slew limiting compiled out: any step saturates to full scale, so the
  // command is taken whole at the next boundary.
  localparam logic [7:0] StepLimit = DUTY_MAX | 8'(SLEW_STEP);
`endif

  logic [PWM_PERIOD_BITS-1:0] periodCntReg;
  logic                       periodStartReg;
  logic [7:0]                 appliedDutyReg;
  logic [7:0]                 dutyNext;
  logic                       periodEnd;
  logic                       raw;

  assign periodEnd = (periodCntReg == DUTY_MAX);
  assign dutyNext  = slewToward(appliedDutyReg, MotorSignal, StepLimit);
  assign raw       = (periodCntReg < appliedDutyReg);

  // Free-running period counter, start pulse and duty shadow loaded on the last count.
  always_ff @(posedge c20k) begin
    if (reset) begin
      periodCntReg   <= '0;
      periodStartReg <= 1'b0;
      appliedDutyReg <= 8'd0;
    end else begin
      periodCntReg   <= periodCntReg + 1'b1;
      periodStartReg <= periodEnd;
      if (periodEnd) begin
        appliedDutyReg <= dutyNext;
      end
    end
  end

  pwm_deadtime #(
    .DEAD_TIME(DEAD_TIME)
  ) deadtimeInst (
    .c20k    (c20k),
    .reset   (reset),
    .raw     (raw),
    .enable  (Enable),
    .kill    (Fault),
    .clear   (FaultClear),
    .highSide(HighSide),
    .lowSide (LowSide),
    .faulted (Faulted)
  );

  assign PeriodStart = periodStartReg;
  assign AppliedDuty = appliedDutyReg;

endmodule
